// File: rtl/fpaddsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fpaddsub_arbiter
// Brief   : Two-requester front end for a shared pipelined FP add/sub unit.
//           Round-robin by default; FPADDSUB_ARB_FIXED_PRI_EN gives A fixed
//           priority. Results are routed back by a {valid, owner} tag pipe.
// Rev     : 1.0  initial release
// ============================================================================
module fpaddsub_arbiter #(
  parameter int LATENCY = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [31:0]      a_x,
  input  logic [31:0]      a_y,
  input  logic             a_op,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [31:0]      b_x,
  input  logic [31:0]      b_y,
  input  logic             b_op,
  output logic             fu_valid,
  output logic [31:0]      fu_x,
  output logic [31:0]      fu_y,
  output logic             fu_op,
  input  logic [31:0]      fu_result,
  output logic             a_res_valid,
  output logic             b_res_valid,
  output logic [31:0]      res_data,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  logic               w_grant_a;
  logic               w_grant_b;
  logic               r_fu_owner;
  logic [LATENCY-1:0] r_tag_v;
  logic [LATENCY-1:0] r_tag_o;

`ifdef FPADDSUB_ARB_FIXED_PRI_EN
  always_comb begin
    w_grant_a = rst & a_valid;
    w_grant_b = rst & b_valid & ~a_valid;
  end
`else
  typedef enum logic [0:0] {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } arb_state_t;

  arb_state_t r_state;
  arb_state_t w_state_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= PRI_A;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_grant_a   = 1'b0;
    w_grant_b   = 1'b0;
    w_state_nxt = r_state;
    // Readies are held low while reset is asserted.
    if (rst) begin
      if (a_valid && (!b_valid || r_state == PRI_A)) w_grant_a = 1'b1;
      else if (b_valid)                              w_grant_b = 1'b1;
    end
    if (w_grant_a)      w_state_nxt = PRI_B;
    else if (w_grant_b) w_state_nxt = PRI_A;
  end
`endif

  assign a_ready = w_grant_a;
  assign b_ready = w_grant_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fu_valid   <= 1'b0;
      fu_x       <= '0;
      fu_y       <= '0;
      fu_op      <= 1'b0;
      r_fu_owner <= 1'b0;
    end else begin
      fu_valid <= w_grant_a | w_grant_b;
      if (w_grant_a) begin
        fu_x       <= a_x;
        fu_y       <= a_y;
        fu_op      <= a_op;
        r_fu_owner <= 1'b0;
      end else if (w_grant_b) begin
        fu_x       <= b_x;
        fu_y       <= b_y;
        fu_op      <= b_op;
        r_fu_owner <= 1'b1;
      end
    end
  end

  // Tag enters alongside fu_valid so its exit lines up with fu_result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag_v <= '0;
      r_tag_o <= '0;
    end else begin
      r_tag_v[0] <= fu_valid;
      r_tag_o[0] <= r_fu_owner;
      for (int i = 1; i < LATENCY; i++) begin
        r_tag_v[i] <= r_tag_v[i-1];
        r_tag_o[i] <= r_tag_o[i-1];
      end
    end
  end

  always_comb begin
    a_res_valid = r_tag_v[LATENCY-1] & ~r_tag_o[LATENCY-1];
    b_res_valid = r_tag_v[LATENCY-1] &  r_tag_o[LATENCY-1];
    res_data    = r_tag_v[LATENCY-1] ? fu_result : 32'h0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_count <= '0;
      b_count <= '0;
    end else begin
      if (w_grant_a && a_count != {CNT_W{1'b1}}) a_count <= a_count + CNT_W'(1);
      if (w_grant_b && b_count != {CNT_W{1'b1}}) b_count <= b_count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpaddsub_arbiter.sv
`default_nettype none
// tb_fpaddsub_arbiter: directed and random stimulus against a cycle-level
// behavioural model of arbitration, issue, result routing and counters.
module tb_fpaddsub_arbiter;
  localparam int LATENCY = 4;
  localparam int CNT_W   = 16;
  localparam int SAT_W   = 4;
  localparam int NS      = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0, a_op = 1'b0, b_op = 1'b0;
  logic [31:0] a_x = '0, a_y = '0, b_x = '0, b_y = '0, fu_result = '0;

  wire             a_ready, b_ready, fu_valid, fu_op, a_res_valid, b_res_valid;
  wire [31:0]      fu_x, fu_y, res_data;
  wire [CNT_W-1:0] a_count, b_count;
  wire             s_a_ready, s_b_ready, s_fu_valid, s_fu_op, s_a_res_valid, s_b_res_valid;
  wire [31:0]      s_fu_x, s_fu_y, s_res_data;
  wire [SAT_W-1:0] s_a_count, s_b_count;

  fpaddsub_arbiter #(.LATENCY(LATENCY), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_x(a_x), .a_y(a_y), .a_op(a_op),
    .b_valid(b_valid), .b_ready(b_ready), .b_x(b_x), .b_y(b_y), .b_op(b_op),
    .fu_valid(fu_valid), .fu_x(fu_x), .fu_y(fu_y), .fu_op(fu_op), .fu_result(fu_result),
    .a_res_valid(a_res_valid), .b_res_valid(b_res_valid), .res_data(res_data),
    .a_count(a_count), .b_count(b_count));

  // Narrow-counter instance for saturation.
  fpaddsub_arbiter #(.LATENCY(LATENCY), .CNT_W(SAT_W)) u_dut_sat (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(s_a_ready), .a_x(a_x), .a_y(a_y), .a_op(a_op),
    .b_valid(b_valid), .b_ready(s_b_ready), .b_x(b_x), .b_y(b_y), .b_op(b_op),
    .fu_valid(s_fu_valid), .fu_x(s_fu_x), .fu_y(s_fu_y), .fu_op(s_fu_op), .fu_result(fu_result),
    .a_res_valid(s_a_res_valid), .b_res_valid(s_b_res_valid), .res_data(s_res_data),
    .a_count(s_a_count), .b_count(s_b_count));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Single-precision add/sub via double arithmetic (normal operands only).
  function automatic real sp2r(input logic [31:0] v);
    logic [10:0] e;
    e = {3'b0, v[30:23]} + 11'd896;
    if (v[30:0] == 31'h0) return 0.0;
    return $bitstoreal({v[31], e, v[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] b;
    logic [10:0] e;
    b = $realtobits(r);
    if (b[62:0] == 63'h0) return 32'h0;
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  function automatic logic [31:0] fp_unit(input logic [31:0] x, input logic [31:0] y, input logic op);
    return r2sp(op ? sp2r(x) - sp2r(y) : sp2r(x) + sp2r(y));
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [7:0] e;
    e = 8'($urandom_range(100, 150));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // Shared unit stand-in: answers exactly LATENCY cycles after fu_valid, junk otherwise.
  bit          fu_sv [NS];
  logic [31:0] fu_sd [NS];
  always @(posedge clk) begin
    #1;
    if (fu_valid) begin
      fu_sd[(cyc + LATENCY) % NS] = fp_unit(fu_x, fu_y, fu_op);
      fu_sv[(cyc + LATENCY) % NS] = 1'b1;
    end
    if (fu_sv[cyc % NS]) begin
      fu_result = fu_sd[cyc % NS];
      fu_sv[cyc % NS] = 1'b0;
    end else begin
      fu_result = $urandom;
    end
  end

  // ---------------- behavioural model ----------------
  // Returns {grant_b, grant_a}.
  function automatic logic [1:0] arb(input logic av, input logic bv, input bit turn_b);
`ifdef FPADDSUB_ARB_FIXED_PRI_EN
    return {bv & ~av, av};
`else
    if (av && bv) return turn_b ? 2'b10 : 2'b01;
    return {bv, av};
`endif
  endfunction

  function automatic int sat_inc(input int v, input int w);
    return (v == (1 << w) - 1) ? v : v + 1;
  endfunction

  bit          m_turn_b = 1'b0;
  bit          m_fv = 1'b0;
  bit          m_fop = 1'b0;
  bit [31:0]   m_fx = '0, m_fy = '0;
  int          m_ac = 0, m_bc = 0, m_ac4 = 0, m_bc4 = 0;
  bit          sv [NS];
  bit          so [NS];
  bit [31:0]   sd [NS];
  wire [1:0]   m_g = rst ? arb(a_valid, b_valid, m_turn_b) : 2'b00;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_turn_b <= 1'b0;
      m_fv <= 1'b0; m_fx <= '0; m_fy <= '0; m_fop <= 1'b0;
      m_ac <= 0; m_bc <= 0; m_ac4 <= 0; m_bc4 <= 0;
      for (int i = 0; i < NS; i++) sv[i] <= 1'b0;
    end else begin
      m_fv <= |m_g;
      sv[cyc % NS] <= 1'b0;
      if (m_g[0]) begin
        m_fx <= a_x; m_fy <= a_y; m_fop <= a_op; m_turn_b <= 1'b1;
        m_ac <= sat_inc(m_ac, CNT_W); m_ac4 <= sat_inc(m_ac4, SAT_W);
        sv[(cyc + LATENCY + 1) % NS] <= 1'b1;
        so[(cyc + LATENCY + 1) % NS] <= 1'b0;
        sd[(cyc + LATENCY + 1) % NS] <= fp_unit(a_x, a_y, a_op);
      end else if (m_g[1]) begin
        m_fx <= b_x; m_fy <= b_y; m_fop <= b_op; m_turn_b <= 1'b0;
        m_bc <= sat_inc(m_bc, CNT_W); m_bc4 <= sat_inc(m_bc4, SAT_W);
        sv[(cyc + LATENCY + 1) % NS] <= 1'b1;
        so[(cyc + LATENCY + 1) % NS] <= 1'b1;
        sd[(cyc + LATENCY + 1) % NS] <= fp_unit(b_x, b_y, b_op);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("a_ready", a_ready, m_g[0]);
    chk("b_ready", b_ready, m_g[1]);
    chk("fu_valid", fu_valid, m_fv);
    chk("fu_x", fu_x, m_fx);
    chk("fu_y", fu_y, m_fy);
    chk("fu_op", fu_op, m_fop);
    chk("a_res_valid", a_res_valid, sv[cyc % NS] & ~so[cyc % NS]);
    chk("b_res_valid", b_res_valid, sv[cyc % NS] & so[cyc % NS]);
    chk("res_data", res_data, sv[cyc % NS] ? sd[cyc % NS] : 32'h0);
    chk("a_count", a_count, m_ac);
    chk("b_count", b_count, m_bc);
    chk("sat_a_count", s_a_count, m_ac4);
    chk("sat_b_count", s_b_count, m_bc4);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    step(); rst = 1'b0;
    step(); rst = 1'b1;
  endtask

  task automatic rand_ops();
    a_x = rnd_fp(); a_y = rnd_fp(); a_op = 1'($urandom);
    b_x = rnd_fp(); b_y = rnd_fp(); b_op = 1'($urandom);
  endtask

  bit ga [8];
  bit gb [8];
  bit own [$];
  int t0, pulses, pct;
  bit found;

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_fu_valid", fu_valid, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_res_data", res_data, 0);
    step(); rst = 1'b1;

    // Single A request: 2.0 + 1.0
    a_valid = 1; a_x = 32'h40000000; a_y = 32'h3F800000; a_op = 0; b_valid = 0;
    @(negedge clk);
    chk("t1_a_ready", a_ready, 1);
    t0 = cyc;
    step(); a_valid = 0;
    @(negedge clk);
    chk("t1_fu_valid", fu_valid, 1);
    chk("t1_fu_x", fu_x, 32'h40000000);
    chk("t1_fu_y", fu_y, 32'h3F800000);
    found = 0;
    for (int i = 0; i < 3 * LATENCY + 4 && !found; i++) begin
      @(negedge clk);
      if (a_res_valid) begin
        found = 1;
        chk("t1_latency", cyc - t0, LATENCY + 1);
        chk("t1_res_data", res_data, 32'h40400000);
      end
    end
    if (!found) chk("t1_timeout", 0, 1);

    // Both valid for 8 cycles
    do_reset();
    a_valid = 1; b_valid = 1; rand_ops();
    own.delete();
    for (int i = 0; i < 8 + 2 * LATENCY + 2; i++) begin
      @(negedge clk);
      if (i < 8) begin ga[i] = a_ready; gb[i] = b_ready; end
      if (a_res_valid) own.push_back(1'b0);
      if (b_res_valid) own.push_back(1'b1);
      step();
      if (i == 7) begin a_valid = 0; b_valid = 0; end
      else rand_ops();
    end
    for (int i = 0; i < 8; i++) begin
`ifdef FPADDSUB_ARB_FIXED_PRI_EN
      chk("rr_grant_a", ga[i], 1);
      chk("rr_grant_b", gb[i], 0);
`else
      chk("rr_grant_a", ga[i], (i % 2) == 0);
      chk("rr_grant_b", gb[i], (i % 2) == 1);
`endif
    end
    chk("rr_result_count", own.size(), 8);
    for (int i = 0; i < own.size() && i < 8; i++) begin
`ifdef FPADDSUB_ARB_FIXED_PRI_EN
      chk("rr_result_owner", own[i], 0);
`else
      chk("rr_result_owner", own[i], i % 2);
`endif
    end
    @(negedge clk);
`ifdef FPADDSUB_ARB_FIXED_PRI_EN
    chk("rr_a_count", a_count, 8);
    chk("rr_b_count", b_count, 0);
`else
    chk("rr_a_count", a_count, 4);
    chk("rr_b_count", b_count, 4);
`endif

    // B alone from PRI_A: granted at once, issued next cycle
    do_reset();
    b_valid = 1; rand_ops();
    @(negedge clk);
    chk("bonly_b_ready", b_ready, 1);
    chk("bonly_a_ready", a_ready, 0);
    step(); b_valid = 0;
    @(negedge clk);
    chk("bonly_fu_valid", fu_valid, 1);

    // Reset mid-flight discards tags
    do_reset();
    a_valid = 1; b_valid = 1;
    for (int i = 0; i < 3; i++) begin rand_ops(); step(); end
    rst = 1'b0;
    #1;
    chk("mid_rst_fu_valid", fu_valid, 0);
    chk("mid_rst_fu_x", fu_x, 0);
    chk("mid_rst_a_ready", a_ready, 0);
    chk("mid_rst_b_ready", b_ready, 0);
    chk("mid_rst_a_count", a_count, 0);
    a_valid = 0; b_valid = 0;
    step(); rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 2 * LATENCY; i++) begin
      @(negedge clk);
      if (a_res_valid || b_res_valid) pulses++;
    end
    chk("mid_rst_no_results", pulses, 0);

    // Counter saturation on the narrow instance
    do_reset();
    a_valid = 1;
    for (int i = 0; i < 20; i++) begin rand_ops(); step(); end
    a_valid = 0;
    @(negedge clk);
    chk("sat_a_count_15", s_a_count, 15);
    chk("wide_a_count_20", a_count, 20);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step();
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 499) == 0) rst = 1'b0;
      case ((i / 300) % 4)
        0: pct = 20;
        1: pct = 50;
        2: pct = 80;
        default: pct = 100;
      endcase
      a_valid = $urandom_range(0, 99) < pct;
      b_valid = $urandom_range(0, 99) < pct;
      rand_ops();
    end
    step(); rst = 1'b1; a_valid = 0; b_valid = 0;
    repeat (2 * LATENCY + 4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fpaddsub_arbiter.md
FPADDSUB_ARBITER -- requirements
Module: fpaddsub_arbiter

Interface
REQ-001 Parameter: LATENCY, default 4, fixed pipeline depth (cycles) of the shared FP add/sub unit from fu_valid to result; legal range 1..16.
REQ-002 Parameter: CNT_W, default 16, width of per-requester issue counters.
REQ-003 clk  input  1  single clock, rising-edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 a_valid, b_valid  input  1 each  requester A/B operation request.
REQ-006 a_ready, b_ready  output  1 each  request accepted this cycle.
REQ-007 a_x, a_y, b_x, b_y  input  32 each  IEEE-754 single operands.
REQ-008 a_op, b_op  input  1 each  OpMode: 0 add, 1 subtract.
REQ-009 fu_valid  output  1  issue strobe to the shared unit.
REQ-010 fu_x, fu_y  output  32 each; fu_op  output  1  operands/OpMode to the shared unit.
REQ-011 fu_result  input  32  unit result, valid exactly LATENCY cycles after its fu_valid.
REQ-012 a_res_valid, b_res_valid  output  1 each; res_data  output  32  routed result.
REQ-013 a_count, b_count  output  CNT_W each  accepted-request counters.

Function
REQ-014 At most one request is granted per cycle; grant is combinational from valids and arbitration state; ready is asserted only for the granted requester.
REQ-015 A transfer occurs when x_valid and x_ready are both high at a rising edge; no other condition accepts a request.
REQ-016 Arbitration state: two states, PRI_A and PRI_B; on a grant to A the next state is PRI_B, on a grant to B it is PRI_A; with no grant the state holds.
REQ-017 Both valid: grant the requester named by the state; single valid: grant it regardless of state; none valid: no grant, fu_valid 0.
REQ-018 Issue path is registered: fu_valid, fu_x, fu_y, fu_op update one cycle after the accepting edge; fu_x/fu_y/fu_op hold their last value when fu_valid is 0.
REQ-019 A tag shift register of depth LATENCY carries {valid, owner} alongside each issue; owner 0 = A, 1 = B.
REQ-020 When the tag exits the shift register with valid 1, exactly one of a_res_valid/b_res_valid pulses for one cycle and res_data equals fu_result in that cycle.
REQ-021 Total latency accept -> res_valid is LATENCY+1 cycles; results return in issue order; one result per cycle sustained throughput.
REQ-022 res_data is 0 when neither res_valid is high.
REQ-023 Results have no back-pressure; requesters must accept them.
REQ-024 a_count/b_count increment by 1 on each accepted transfer of that requester; saturate at all-ones, no wrap.
REQ-025 Simultaneous issue and result in the same cycle are independent; both occur.

Reset
REQ-026 On rst low, asynchronously: state = PRI_A, all tag valids 0, fu_valid 0, fu_x/fu_y 0, fu_op 0, a/b_res_valid 0, res_data 0, a/b_count 0.
REQ-027 Reset mid-operation discards all in-flight tags; no res_valid pulse follows for operations issued before reset, even if fu_result later changes.
REQ-028 While rst is low, a_ready and b_ready are 0.

Configuration
REQ-029 Macro FPADDSUB_ARB_FIXED_PRI_EN: when defined, A always wins when both are valid and the arbitration state is unused; when undefined, round-robin per REQ-016/017 applies.

Verification
REQ-030 Single A request, a_x=0x40000000 (2.0), a_y=0x3F800000 (1.0), a_op=0 -> fu_valid 1 cycle later with same operands; a_res_valid pulses at cycle LATENCY+1 with res_data = model fu_result 0x40400000.
REQ-031 A and B valid continuously 8 cycles (default build) -> grants alternate A,B,A,B...; results alternate owner in same order; a_count=b_count=4.
REQ-032 Same stimulus with FPADDSUB_ARB_FIXED_PRI_EN defined -> A granted all 8 cycles; b_ready stays 0; a_count=8, b_count=0.
REQ-033 Issue 3 ops, assert rst low for 1 cycle at cycle 2 -> all outputs zero immediately; no res_valid in next 2*LATENCY cycles.
REQ-034 CNT_W=4, A valid 20 cycles alone -> a_count saturates at 15.
REQ-035 B only valid, state PRI_A -> B granted immediately, no bubble.
